// File: rtl/ext_int_input_unit_pkg.sv
// Shared types and defaults for the external interrupt input front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package int_pkg;

  // Per-channel event selection, encoded as it appears on int_mode.
  typedef enum logic [1:0] {
    INT_RISE  = 2'b00,
    INT_FALL  = 2'b01,
    INT_BOTH  = 2'b10,
    INT_LEVEL = 2'b11
  } int_mode_e;

  localparam int SYNC_STAGES_DEF = 2;

  // int_id width; a single channel still gets a 1-bit ID.
  function automatic int id_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/ext_int_input_unit_if.sv
// Pin/config/status bundle between interrupt sources, software regs and controller.
// Latency: n/a (wiring only).
// Backpressure: none; pending bits are level-held until software clears them.
interface ext_int_input_unit_if #(
  parameter int N_CH   = 8,
  parameter int FILT_W = 4,
  parameter int ID_W   = int_pkg::id_width(N_CH)
);
  logic [N_CH-1:0]   int_in;
  logic [2*N_CH-1:0] int_mode;
  logic [N_CH-1:0]   filt_en;
  logic [FILT_W-1:0] filt_len;
  logic [N_CH-1:0]   int_clr;
  logic [N_CH-1:0]   int_mask;
  logic [N_CH-1:0]   int_pend;
  logic              int_req;
  logic [ID_W-1:0]   int_id;
  logic              int_id_vld;

  // Side that drives pins and configuration and observes the request.
  modport master (
    output int_in, int_mode, filt_en, filt_len, int_clr, int_mask,
    input  int_pend, int_req, int_id, int_id_vld
  );

  // The interrupt input unit itself.
  modport slave (
    input  int_in, int_mode, filt_en, filt_len, int_clr, int_mask,
    output int_pend, int_req, int_id, int_id_vld
  );
endinterface

// File: rtl/ext_int_input_unit_channel.sv
// One interrupt channel: synchroniser, glitch filter, edge/level detect, pending latch.
// Latency: pin sampled at edge k -> pend_o after edge k+SYNC_STAGES+1 (+filt_len when filtering).
// Backpressure: none; the pending bit holds until cleared (set wins over clear).
module ext_int_channel
  import int_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pin_i,
  input  int_mode_e         mode_i,
  input  logic              filt_en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              clr_i,
  output logic              pend_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   filt_q, filt_d;
  logic                   filt_dly_q;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   rise, fall, evt;

  assign sync = sync_q[SYNC_STAGES-1];

  // Filter next state: the synchronised value must disagree for filt_len+1 cycles.
  // A shortened filt_len mid-count is compared immediately; cnt is not reset.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (!filt_en_i || (filt_len_i == '0)) begin
      filt_d = sync;
      cnt_d  = '0;
    end else if (sync == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == filt_len_i) begin
      filt_d = sync;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Event select; filt_dly_q tracks in every mode so a mode switch makes no false edge.
  always_comb begin
    rise = filt_q & ~filt_dly_q;
    fall = ~filt_q & filt_dly_q;
    unique case (mode_i)
      INT_RISE:  evt = rise;
      INT_FALL:  evt = fall;
      INT_BOTH:  evt = rise | fall;
      INT_LEVEL: evt = filt_q;
      default:   evt = 1'b0;
    endcase
    pend_d = evt | (pend_q & ~clr_i);
  end

  // State registers: sync chain, filter, edge history and the pending latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pin_i};
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/ext_int_input_unit.sv
// Multi-channel external/NMI interrupt front end with masked lowest-index request.
// Latency: filter off, pin sampled at edge k -> int_pend after edge k+SYNC_STAGES+1; req/id are 0-cycle from pend.
// Backpressure: none; requests stay asserted while an unmasked bit is pending.
module ext_int_input_unit
  import int_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = 4
) (
  input logic                clk,
  input logic                rst,
  ext_int_input_unit_if.slave bus
);

  localparam int ID_W = id_width(N_CH);

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] req_vec;
  logic [ID_W-1:0] id;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ext_int_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .pin_i      (bus.int_in[g]),
      .mode_i     (int_mode_e'(bus.int_mode[2*g+1 -: 2])),
      .filt_en_i  (bus.filt_en[g]),
      .filt_len_i (bus.filt_len),
      .clr_i      (bus.int_clr[g]),
      .pend_o     (pend[g])
    );
  end

  assign req_vec = pend & ~bus.int_mask;

  // Lowest-index priority: scan downward so the smallest set index is written last.
  always_comb begin
    id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_vec[i]) id = ID_W'(i);
    end
  end

  assign bus.int_pend   = pend;
  assign bus.int_req    = |req_vec;
  assign bus.int_id     = id;
  assign bus.int_id_vld = |req_vec;

endmodule

// File: tb/tb_ext_int_input_unit.sv
// Directed bench for ext_int_input_unit: latency, mask/priority, filter, level, set-vs-clear, reset.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_ext_int_input_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  ext_int_input_unit_if #(.N_CH(8), .FILT_W(4)) bus ();

  ext_int_input_unit #(.N_CH(8), .SYNC_STAGES(2), .FILT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_clr(input int ch);
    bus.int_clr[ch] = 1'b1;
    tick();
    bus.int_clr[ch] = 1'b0;
  endtask

  initial begin
    bus.int_in   = '0;
    bus.int_mode = '0;
    bus.filt_en  = '0;
    bus.filt_len = '0;
    bus.int_clr  = '0;
    bus.int_mask = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);

    // Reset state
    chk("rst_pend", 32'(bus.int_pend), 32'h00);
    chk("rst_req",  32'(bus.int_req), 32'h0);
    chk("rst_id",   32'(bus.int_id), 32'h0);
    chk("rst_vld",  32'(bus.int_id_vld), 32'h0);

    // 1: ch3 rise, filter off, 3-cycle latency
    bus.int_in[3] = 1'b1;
    tick(3);
    chk("t1_pend_early", 32'(bus.int_pend), 32'h00);
    tick();
    chk("t1_pend", 32'(bus.int_pend), 32'h08);
    chk("t1_req",  32'(bus.int_req), 32'h1);
    chk("t1_id",   32'(bus.int_id), 32'h3);
    chk("t1_vld",  32'(bus.int_id_vld), 32'h1);
    pulse_clr(3);
    chk("t1_clr", 32'(bus.int_pend), 32'h00);

    // 2: ch2 and ch5 pending, ch2 masked
    bus.int_in[2] = 1'b1;
    bus.int_in[5] = 1'b1;
    bus.int_mask[2] = 1'b1;
    tick(4);
    chk("t2_pend", 32'(bus.int_pend), 32'h24);
    chk("t2_id",   32'(bus.int_id), 32'h5);
    pulse_clr(5);
    chk("t2_req",  32'(bus.int_req), 32'h0);
    chk("t2_pend_masked", 32'(bus.int_pend), 32'h04);
    bus.int_mask[2] = 1'b0;
    tick();
    chk("t2_id_unmask", 32'(bus.int_id), 32'h2);
    bus.int_in[2] = 1'b0;
    bus.int_in[3] = 1'b0;
    bus.int_in[5] = 1'b0;
    tick(4);
    pulse_clr(2);
    chk("t2_fall_no_evt", 32'(bus.int_pend), 32'h00);

    // 3: ch0 filtered, filt_len=3
    bus.filt_en[0] = 1'b1;
    bus.filt_len   = 4'd3;
    bus.int_in[0]  = 1'b1;
    tick(3);
    bus.int_in[0]  = 1'b0;
    tick(10);
    chk("t3_glitch", 32'(bus.int_pend), 32'h00);
    bus.int_in[0] = 1'b1;
    tick(4);
    bus.int_in[0] = 1'b0;
    tick(2);
    chk("t3_pend_early", 32'(bus.int_pend), 32'h00);
    tick();
    chk("t3_pend", 32'(bus.int_pend), 32'h01);
    tick(10);
    pulse_clr(0);
    bus.filt_en[0] = 1'b0;
    chk("t3_clr", 32'(bus.int_pend), 32'h00);

    // 4: ch1 level mode, clear while high does not stick
    bus.int_mode[3:2] = 2'b11;
    bus.int_in[1] = 1'b1;
    tick(5);
    chk("t4_level", 32'(bus.int_pend), 32'h02);
    pulse_clr(1);
    chk("t4_clr_high", 32'(bus.int_pend), 32'h02);
    bus.int_in[1] = 1'b0;
    tick(5);
    chk("t4_sticky", 32'(bus.int_pend), 32'h02);
    pulse_clr(1);
    chk("t4_clr_low", 32'(bus.int_pend), 32'h00);

    // 5: ch4 both edges, set beats coincident clear
    bus.int_mode[9:8] = 2'b10;
    bus.int_in[4] = 1'b1;
    tick(3);
    pulse_clr(4);
    chk("t5_set_wins", 32'(bus.int_pend), 32'h10);
    pulse_clr(4);
    chk("t5_clr", 32'(bus.int_pend), 32'h00);
    bus.int_in[4] = 1'b0;
    tick(4);
    chk("t5_fall", 32'(bus.int_pend), 32'h10);

    // 6: reset with ch4/ch6 pending and ch0 filter mid-count
    bus.int_in[6] = 1'b1;
    tick(4);
    chk("t6_pend", 32'(bus.int_pend), 32'h50);
    bus.filt_en[0] = 1'b1;
    bus.int_in[0]  = 1'b1;
    tick(4);
    bus.int_in = '0;
    rst = 1'b1;
    tick();
    chk("t6_rst_pend", 32'(bus.int_pend), 32'h00);
    chk("t6_rst_req",  32'(bus.int_req), 32'h0);
    chk("t6_rst_id",   32'(bus.int_id), 32'h0);
    chk("t6_rst_vld",  32'(bus.int_id_vld), 32'h0);
    rst = 1'b0;
    tick(10);
    chk("t6_post_rst", 32'(bus.int_pend), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
